// File: rtl/fir_out_decimator.sv
// Output stage behind the FIR: decimates the sample stream by 2^decim_log2 and buffers results in a
// small FIFO with a valid/ready output. Optional group averaging is enabled by defining FIR_OUT_AVG_EN.
module fir_out_decimator #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int LOG2_MAX = 7
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_W-1:0]          din,
  input  logic                       valid_in,
  input  logic [2:0]                 decim_log2,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = (LOG2_MAX > 0) ? LOG2_MAX : 1;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        k_in_s, k_eff_s;
  logic [PH_W-1:0]   mask_s;
  logic              complete_s;
  logic [DATA_W-1:0] result_s;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              pop_s, full_s, wr_en_s, drop_s;

  // Group bookkeeping; a new factor only takes hold on the first sample of a group
  always_comb begin
    k_in_s     = (int'(decim_log2) > LOG2_MAX) ? 3'(LOG2_MAX) : decim_log2;
    k_eff_s    = (phase_q == {PH_W{1'b0}}) ? k_in_s : k_q;
    mask_s     = ~({PH_W{1'b1}} << k_eff_s);
    complete_s = valid_in && (phase_q == mask_s);
    phase_d    = phase_q;
    k_d        = k_q;
    if (valid_in) begin
      k_d     = k_eff_s;
      phase_d = complete_s ? {PH_W{1'b0}} : phase_q + {{(PH_W-1){1'b0}}, 1'b1};
    end else begin
      phase_d = phase_q;
    end
  end

`ifdef FIR_OUT_AVG_EN
  localparam int ACC_W = DATA_W + LOG2_MAX;

  logic signed [ACC_W-1:0] acc_q, acc_d, din_ext_s, sum_s, rnd_s, mean_s;

  // Running sum restarts with the group's first sample; mean rounds half-up
  always_comb begin
    din_ext_s = {{LOG2_MAX{din[DATA_W-1]}}, din};
    sum_s     = (phase_q == {PH_W{1'b0}}) ? din_ext_s : acc_q + din_ext_s;
    rnd_s     = (k_eff_s == 3'd0) ? {ACC_W{1'b0}} : (ACC_W'(1) << (k_eff_s - 3'd1));
    mean_s    = (sum_s + rnd_s) >>> k_eff_s;
    result_s  = mean_s[DATA_W-1:0];
    acc_d     = valid_in ? sum_s : acc_q;
  end

  // Accumulator register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign result_s = din;
`endif

  // FIFO control; a push into a full FIFO only survives if a pop frees the slot on the same edge
  always_comb begin
    pop_s    = m_valid && m_ready;
    full_s   = (level_q == LVL_W'(DEPTH));
    wr_en_s  = complete_s && (!full_s || pop_s);
    drop_s   = complete_s && full_s && !pop_s;
    wr_ptr_d = wr_en_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q  <= {PH_W{1'b0}};
      k_q      <= 3'd0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage, cleared so the head reads zero out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= result_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign m_data   = mem_q[rd_ptr_q];
  assign m_valid  = (level_q != {LVL_W{1'b0}});
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed self-checking bench for fir_out_decimator; expected values are hand-computed.
// Averaging-mode expectations are selected when FIR_OUT_AVG_EN is defined.
module tb_fir_out_decimator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        valid_in = 1'b0;
  logic [2:0]  decim_log2 = 3'd0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  level;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  fir_out_decimator dut (
    .clk(clk), .resetn(resetn), .din(din), .valid_in(valid_in), .decim_log2(decim_log2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    din = d;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  logic [15:0] exp_g1, exp_g2, exp_t5a, exp_t5b;

  initial begin
`ifdef FIR_OUT_AVG_EN
    exp_g1 = 16'd3;  exp_g2 = 16'd7;  exp_t5a = 16'd13; exp_t5b = 16'd16;
`else
    exp_g1 = 16'd4;  exp_g2 = 16'd8;  exp_t5a = 16'd14; exp_t5b = 16'd16;
`endif
    #12;
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: pass-through with a ready consumer
    m_ready = 1'b1;
    push(16'h1234);
    chk("t1_v1", 32'(m_valid), 32'd1);
    chk("t1_d1", 32'(m_data), 32'h1234);
    push(16'h8000);
    chk("t1_v2", 32'(m_valid), 32'd1);
    chk("t1_d2", 32'(m_data), 32'h8000);
    chk("t1_lvl2", 32'(level), 32'd1);
    tick();
    chk("t1_lvl0", 32'(level), 32'd0);
    chk("t1_v0", 32'(m_valid), 32'd0);

    // 2: decimate by 4
    m_ready = 1'b0;
    decim_log2 = 3'd2;
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
      if (i == 3) chk("t2_lvl_i3", 32'(level), 32'd0);
      if (i == 4) chk("t2_lvl_i4", 32'(level), 32'd1);
    end
    chk("t2_lvl", 32'(level), 32'd2);
    chk("t2_d1", 32'(m_data), 32'(exp_g1));
    m_ready = 1'b1;
    tick();
    chk("t2_d2", 32'(m_data), 32'(exp_g2));
    tick();
    chk("t2_empty", 32'(level), 32'd0);

    // 3: fill, overflow, set-wins-over-clear, clear
    m_ready = 1'b0;
    decim_log2 = 3'd0;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    chk("t3_lvl8", 32'(level), 32'd8);
    chk("t3_ovf0", 32'(overflow), 32'd0);
    push(16'h0200);
    chk("t3_lvl_ovf", 32'(level), 32'd8);
    chk("t3_ovf1", 32'(overflow), 32'd1);
    chk("t3_head", 32'(m_data), 32'h0100);
    clr_ovf = 1'b1;
    push(16'h0201);
    chk("t3_setwins", 32'(overflow), 32'd1);
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr", 32'(overflow), 32'd0);

    // 4: full with simultaneous push and pop
    m_ready = 1'b1;
    push(16'hABCD);
    m_ready = 1'b0;
    chk("t4_lvl", 32'(level), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_head", 32'(m_data), 32'h0101);
    m_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      chk("t4_drain", 32'(m_data), 32'h0100 + 32'(i));
    end
    tick();
    chk("t4_newest", 32'(m_data), 32'hABCD);
    tick();
    chk("t4_empty", 32'(level), 32'd0);

    // 5: factor change mid-group
    m_ready = 1'b0;
    decim_log2 = 3'd2;
    push(16'd11);
    push(16'd12);
    decim_log2 = 3'd1;
    push(16'd13);
    chk("t5_lvl_s3", 32'(level), 32'd0);
    push(16'd14);
    chk("t5_lvl_s4", 32'(level), 32'd1);
    push(16'd15);
    chk("t5_lvl_s5", 32'(level), 32'd1);
    push(16'd16);
    chk("t5_lvl_s6", 32'(level), 32'd2);
    chk("t5_d1", 32'(m_data), 32'(exp_t5a));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t5_d2", 32'(m_data), 32'(exp_t5b));

    // 6: asynchronous reset with entries and a partial group
    decim_log2 = 3'd0;
    push(16'h0021);
    push(16'h0022);
    chk("t6_lvl3", 32'(level), 32'd3);
    decim_log2 = 3'd1;
    push(16'h0023);
    #1 resetn = 1'b0;
    #1;
    chk("t6_mvalid", 32'(m_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    push(16'h0031);
    chk("t6_ph_lvl0", 32'(level), 32'd0);
    push(16'h0032);
    chk("t6_ph_lvl1", 32'(level), 32'd1);
    chk("t6_ph_data", 32'(m_data), 32'h0032);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
